// File: rtl/burst_cmd_pkg.sv
// ============================================================================
// burst_cmd_pkg : shared constants, command record and request-check helper
// Revision      : 1.0
// ============================================================================
`default_nettype none

package burst_cmd_pkg;

    localparam int CMD_ADDR_W = 64;
    localparam int BEAT_BYTES = 64;
    localparam int PAGE_BYTES = 4096;

    localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr;
        logic [7:0]            len;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Span is kept 15 bits wide so a 256-beat burst cannot wrap and hide a crossing.
    function automatic logic req_violation(input logic [11:0] page_off,
                                           input logic [7:0]  len);
        logic [14:0] span;
        span = {3'b000, page_off} + (({7'd0, len} + 15'd1) * 15'(BEAT_BYTES));
        return (page_off[$clog2(BEAT_BYTES)-1:0] != '0) || (span > 15'(PAGE_BYTES));
    endfunction

endpackage

`default_nettype wire

// File: rtl/burst_cmd_responder_if.sv
// ============================================================================
// burst_cmd_responder_if : burst-request handshake plus AXI AR/AW/W/B signals
// Revision               : 1.0
// ============================================================================
`default_nettype none

interface burst_cmd_responder_if #(
    parameter int ADDR_W = 64
);
    logic              rd_req;
    logic [7:0]        rd_len;
    logic [ADDR_W-1:0] rd_address;
    logic              rd_req_ack;
    logic              wr_req;
    logic [7:0]        wr_len;
    logic [ADDR_W-1:0] wr_address;
    logic              wr_req_ack;
    logic              bready;
    logic              bresp;
    logic              err;

    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic [7:0]        m_axi_awlen;
    logic [2:0]        m_axi_awsize;
    logic [1:0]        m_axi_awburst;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic              w_beat;
    logic              m_axi_wlast;
    logic              m_axi_bvalid;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bready;

    modport slave (
        input  rd_req, rd_len, rd_address, wr_req, wr_len, wr_address, bready,
        input  m_axi_arready, m_axi_awready, w_beat, m_axi_bvalid, m_axi_bresp,
        output rd_req_ack, wr_req_ack, bresp, err,
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        output m_axi_wlast, m_axi_bready
    );

    modport master (
        output rd_req, rd_len, rd_address, wr_req, wr_len, wr_address, bready,
        output m_axi_arready, m_axi_awready, w_beat, m_axi_bvalid, m_axi_bresp,
        input  rd_req_ack, wr_req_ack, bresp, err,
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        input  m_axi_wlast, m_axi_bready
    );

endinterface

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// ============================================================================
// sync_fifo_fwft : first-word-fall-through synchronous FIFO, head on dout
// Revision       : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] din,
    output logic                  full,
    input  wire logic             pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wptr;
    logic [PTR_W:0]   r_rptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full   = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                    (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign empty  = (r_wptr == r_rptr);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = r_mem[r_rptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/burst_cmd_responder.sv
// ============================================================================
// burst_cmd_responder : queues burst requests onto AXI AR/AW, makes WLAST, B pulses
// Revision            : 1.0
// ============================================================================
`default_nettype none

module burst_cmd_responder
    import burst_cmd_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int ADDR_W    = 64
) (
    input  wire logic            clk,
    input  wire logic            rst,
    burst_cmd_responder_if.slave bus
);
    cmd_t       w_rd_in;
    cmd_t       w_rd_head;
    cmd_t       w_aw_in;
    cmd_t       w_aw_head;
    logic       w_rd_full;
    logic       w_rd_empty;
    logic       w_aw_full;
    logic       w_aw_empty;
    logic       w_wlen_full;
    logic       w_wlen_empty;
    logic [7:0] w_wlen_head;

    logic       w_rd_ack;
    logic       w_wr_ack;
    logic       w_arvalid;
    logic       w_awvalid;
    logic       w_rd_pop;
    logic       w_aw_pop;
    logic       w_wlast;
    logic       w_wlen_pop;
    logic       w_b_hs;
    logic       w_err_set;

    logic [7:0] r_beat_cnt;
    logic [7:0] r_outstanding;
    logic       r_bresp;
    logic       r_err;

    always_comb begin
        w_rd_in                  = '0;
        w_rd_in.addr[ADDR_W-1:0] = bus.rd_address;
        w_rd_in.len              = bus.rd_len;
        w_aw_in                  = '0;
        w_aw_in.addr[ADDR_W-1:0] = bus.wr_address;
        w_aw_in.len              = bus.wr_len;
    end

    // Acks never look at a same-cycle pop, so a full FIFO always stalls the initiator.
    assign w_rd_ack   = bus.rd_req & ~w_rd_full & ~rst;
    assign w_wr_ack   = bus.wr_req & ~w_aw_full & ~w_wlen_full & ~rst;
    assign w_arvalid  = ~w_rd_empty & ~rst;
    assign w_awvalid  = ~w_aw_empty & ~rst;
    assign w_rd_pop   = w_arvalid & bus.m_axi_arready;
    assign w_aw_pop   = w_awvalid & bus.m_axi_awready;
    assign w_wlast    = ~w_wlen_empty & (r_beat_cnt == w_wlen_head) & ~rst;
    assign w_wlen_pop = bus.w_beat & w_wlast;
    assign w_b_hs     = bus.m_axi_bvalid & bus.bready;

    assign w_err_set = (w_rd_ack & req_violation(bus.rd_address[11:0], bus.rd_len))
                     | (w_wr_ack & req_violation(bus.wr_address[11:0], bus.wr_len))
                     | (bus.w_beat & w_wlen_empty)
                     | (w_b_hs & (bus.m_axi_bresp != AXI_RESP_OKAY))
                     | (w_b_hs & (r_outstanding == 8'd0));

    sync_fifo_fwft #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_rd_fifo (
        .clk(clk), .rst(rst),
        .push(w_rd_ack), .din(w_rd_in), .full(w_rd_full),
        .pop(w_rd_pop), .dout(w_rd_head), .empty(w_rd_empty)
    );

    sync_fifo_fwft #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_aw_fifo (
        .clk(clk), .rst(rst),
        .push(w_wr_ack), .din(w_aw_in), .full(w_aw_full),
        .pop(w_aw_pop), .dout(w_aw_head), .empty(w_aw_empty)
    );

    sync_fifo_fwft #(.WIDTH(8), .DEPTH(CMD_DEPTH)) u_wlen_fifo (
        .clk(clk), .rst(rst),
        .push(w_wr_ack), .din(bus.wr_len), .full(w_wlen_full),
        .pop(w_wlen_pop), .dout(w_wlen_head), .empty(w_wlen_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt    <= 8'd0;
            r_outstanding <= 8'd0;
            r_bresp       <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_bresp <= w_b_hs;
            r_err   <= r_err | w_err_set;
            if (bus.w_beat && !w_wlen_empty) begin
                r_beat_cnt <= w_wlast ? 8'd0 : r_beat_cnt + 8'd1;
            end
            case ({w_aw_pop, w_b_hs})
                2'b10:   r_outstanding <= r_outstanding + 8'd1;
                2'b01:   if (r_outstanding != 8'd0) r_outstanding <= r_outstanding - 8'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign bus.rd_req_ack    = w_rd_ack;
    assign bus.wr_req_ack    = w_wr_ack;
    assign bus.m_axi_araddr  = w_rd_head.addr[ADDR_W-1:0];
    assign bus.m_axi_arlen   = w_rd_head.len;
    assign bus.m_axi_arsize  = AXI_SIZE_64B;
    assign bus.m_axi_arburst = AXI_BURST_INCR;
    assign bus.m_axi_arvalid = w_arvalid;
    assign bus.m_axi_awaddr  = w_aw_head.addr[ADDR_W-1:0];
    assign bus.m_axi_awlen   = w_aw_head.len;
    assign bus.m_axi_awsize  = AXI_SIZE_64B;
    assign bus.m_axi_awburst = AXI_BURST_INCR;
    assign bus.m_axi_awvalid = w_awvalid;
    assign bus.m_axi_wlast   = w_wlast;
    assign bus.m_axi_bready  = bus.bready;
    assign bus.bresp         = r_bresp;
    assign bus.err           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_burst_cmd_responder.sv
// ============================================================================
// tb_burst_cmd_responder : directed scenarios plus random traffic against a queue model
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_burst_cmd_responder;
    localparam int DEPTH = 4;
    localparam int AW    = 64;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } cmd_s;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    burst_cmd_responder_if #(.ADDR_W(AW)) bus ();

    burst_cmd_responder #(.CMD_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.rd_req = 0; bus.rd_len = '0; bus.rd_address = '0;
        bus.wr_req = 0; bus.wr_len = '0; bus.wr_address = '0;
        bus.bready = 0; bus.m_axi_arready = 0; bus.m_axi_awready = 0;
        bus.w_beat = 0; bus.m_axi_bvalid = 0; bus.m_axi_bresp = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; idle_inputs();
        @(negedge clk); rst = 1'b0;
    endtask

    // Reference rule for request errors, plain integer arithmetic.
    function automatic bit req_bad(input logic [63:0] a, input logic [7:0] l);
        int off;
        off = int'(a[11:0]);
        return ((off % 64) != 0) || (off + (int'(l) + 1) * 64 > 4096);
    endfunction

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a = 64'($urandom_range(0, 255)) * 64'd4096 + 64'($urandom_range(0, 63)) * 64'd64;
        if ($urandom_range(0, 15) == 0) a = a + 64'd8;
        return a;
    endfunction

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; idle_inputs();
        bus.rd_req = 1; bus.wr_req = 1; bus.rd_address = 64'h40; bus.wr_address = 64'h80;
        #1;
        n_checks++; if (bus.rd_req_ack !== 1'b0) begin n_fail++; $display("FAIL rst_rd_ack: got %0b want 0", bus.rd_req_ack); end
        n_checks++; if (bus.wr_req_ack !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ack: got %0b want 0", bus.wr_req_ack); end
        n_checks++; if (bus.m_axi_wlast !== 1'b0) begin n_fail++; $display("FAIL rst_wlast: got %0b want 0", bus.m_axi_wlast); end
        @(negedge clk); rst = 1'b0; idle_inputs(); #1;
        n_checks++; if (bus.m_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %0b want 0", bus.m_axi_arvalid); end
        n_checks++; if (bus.m_axi_awvalid !== 1'b0) begin n_fail++; $display("FAIL rst_awvalid: got %0b want 0", bus.m_axi_awvalid); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", bus.err); end
        n_checks++; if (bus.bresp !== 1'b0) begin n_fail++; $display("FAIL rst_bresp: got %0b want 0", bus.bresp); end
    endtask

    task automatic test_read_single();
        @(negedge clk); idle_inputs();
        bus.rd_req = 1; bus.rd_address = 64'h1000; bus.rd_len = 8'h3F; bus.m_axi_arready = 1; #1;
        n_checks++; if (bus.rd_req_ack !== 1'b1) begin n_fail++; $display("FAIL rs_ack: got %0b want 1", bus.rd_req_ack); end
        @(negedge clk); bus.rd_req = 0; #1;
        n_checks++; if (bus.m_axi_arvalid !== 1'b1) begin n_fail++; $display("FAIL rs_arvalid: got %0b want 1", bus.m_axi_arvalid); end
        n_checks++; if (bus.m_axi_araddr !== 64'h1000) begin n_fail++; $display("FAIL rs_araddr: got %0h want 1000", bus.m_axi_araddr); end
        n_checks++; if (bus.m_axi_arlen !== 8'h3F) begin n_fail++; $display("FAIL rs_arlen: got %0h want 3f", bus.m_axi_arlen); end
        n_checks++; if (bus.m_axi_arsize !== 3'b110) begin n_fail++; $display("FAIL rs_arsize: got %0b want 110", bus.m_axi_arsize); end
        n_checks++; if (bus.m_axi_arburst !== 2'b01) begin n_fail++; $display("FAIL rs_arburst: got %0b want 01", bus.m_axi_arburst); end
        @(negedge clk); #1;
        n_checks++; if (bus.m_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL rs_popped: got %0b want 0", bus.m_axi_arvalid); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rs_err: got %0b want 0", bus.err); end
    endtask

    task automatic test_read_backpressure();
        cmd_s q[$];
        int   sent = 0;
        int   dut_acks = 0;
        bit   e_ack;
        idle_inputs();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            bus.m_axi_arready = (c >= 6);
            bus.rd_req = (sent < 5);
            bus.rd_address = 64'h2000 + 64'(sent * 256);
            bus.rd_len = 8'(sent);
            #1;
            e_ack = (sent < 5) && (q.size() < DEPTH);
            n_checks++; if (bus.rd_req_ack !== e_ack) begin n_fail++; $display("FAIL bp_ack c%0d: got %0b want %0b", c, bus.rd_req_ack, e_ack); end
            n_checks++; if (bus.m_axi_arvalid !== (q.size() != 0)) begin n_fail++; $display("FAIL bp_arvalid c%0d: got %0b want %0b", c, bus.m_axi_arvalid, q.size() != 0); end
            if (q.size() != 0) begin
                n_checks++; if (bus.m_axi_araddr !== q[0].addr || bus.m_axi_arlen !== q[0].len) begin
                    n_fail++; $display("FAIL bp_head c%0d: got %0h/%0h want %0h/%0h", c, bus.m_axi_araddr, bus.m_axi_arlen, q[0].addr, q[0].len);
                end
            end
            if (bus.rd_req_ack === 1'b1) dut_acks++;
            if (c == 5) begin
                n_checks++; if (dut_acks != 4) begin n_fail++; $display("FAIL bp_acks_blocked: got %0d want 4", dut_acks); end
            end
            if (q.size() != 0 && bus.m_axi_arready) void'(q.pop_front());
            if (e_ack) begin q.push_back('{addr: bus.rd_address, len: bus.rd_len}); sent++; end
        end
        n_checks++; if (dut_acks != 5) begin n_fail++; $display("FAIL bp_acks_total: got %0d want 5", dut_acks); end
    endtask

    task automatic test_write_wlast();
        logic exp_wl [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk); idle_inputs();
        bus.m_axi_awready = 1; bus.wr_req = 1; bus.wr_address = 64'h3000; bus.wr_len = 8'd0; #1;
        n_checks++; if (bus.wr_req_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack0: got %0b want 1", bus.wr_req_ack); end
        @(negedge clk); bus.wr_address = 64'h4000; bus.wr_len = 8'd3; #1;
        n_checks++; if (bus.wr_req_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack1: got %0b want 1", bus.wr_req_ack); end
        n_checks++; if (bus.m_axi_awvalid !== 1'b1 || bus.m_axi_awaddr !== 64'h3000 || bus.m_axi_awlen !== 8'd0) begin
            n_fail++; $display("FAIL wr_aw0: got %0b/%0h/%0h want 1/3000/0", bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awlen);
        end
        for (int b = 0; b < 5; b++) begin
            @(negedge clk); bus.wr_req = 0; bus.w_beat = 1; #1;
            if (b == 0) begin
                n_checks++; if (bus.m_axi_awvalid !== 1'b1 || bus.m_axi_awaddr !== 64'h4000 || bus.m_axi_awlen !== 8'd3) begin
                    n_fail++; $display("FAIL wr_aw1: got %0b/%0h/%0h want 1/4000/3", bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awlen);
                end
            end
            n_checks++; if (bus.m_axi_wlast !== exp_wl[b]) begin n_fail++; $display("FAIL wr_wlast beat%0d: got %0b want %0b", b + 1, bus.m_axi_wlast, exp_wl[b]); end
        end
        @(negedge clk); bus.w_beat = 0; #1;
        n_checks++; if (bus.m_axi_wlast !== 1'b0) begin n_fail++; $display("FAIL wr_wlen_empty: got %0b want 0", bus.m_axi_wlast); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %0b want 0", bus.err); end
    endtask

    task automatic test_b_pulses();
        logic exp_p [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); bus.bready = 1; bus.m_axi_bvalid = (c < 2); bus.m_axi_bresp = 2'b00; #1;
            n_checks++; if (bus.bresp !== exp_p[c]) begin n_fail++; $display("FAIL b_pulse c%0d: got %0b want %0b", c, bus.bresp, exp_p[c]); end
            n_checks++; if (bus.m_axi_bready !== 1'b1) begin n_fail++; $display("FAIL b_bready c%0d: got %0b want 1", c, bus.m_axi_bready); end
        end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL b_err_ok: got %0b want 0", bus.err); end
        @(negedge clk); bus.m_axi_bvalid = 1;
        @(negedge clk); bus.m_axi_bvalid = 0; #1;
        n_checks++; if (bus.bresp !== 1'b1) begin n_fail++; $display("FAIL b_pulse3: got %0b want 1", bus.bresp); end
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL b_underflow_err: got %0b want 1", bus.err); end
        @(negedge clk); bus.bready = 0; bus.m_axi_bvalid = 1; #1;
        n_checks++; if (bus.m_axi_bready !== 1'b0) begin n_fail++; $display("FAIL b_bready_low: got %0b want 0", bus.m_axi_bready); end
        @(negedge clk); bus.m_axi_bvalid = 0; #1;
        n_checks++; if (bus.bresp !== 1'b0) begin n_fail++; $display("FAIL b_no_hs: got %0b want 0", bus.bresp); end
        do_reset();
    endtask

    task automatic test_errors();
        @(negedge clk); idle_inputs();
        bus.m_axi_awready = 1; bus.wr_req = 1; bus.wr_address = 64'hFC0; bus.wr_len = 8'd0;
        @(negedge clk); bus.wr_req = 0; #1;
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL e_4k_exact: got %0b want 0", bus.err); end
        @(negedge clk); bus.wr_req = 1; bus.wr_len = 8'd1; #1;
        n_checks++; if (bus.wr_req_ack !== 1'b1) begin n_fail++; $display("FAIL e_4k_ack: got %0b want 1", bus.wr_req_ack); end
        @(negedge clk); bus.wr_req = 0; #1;
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL e_4k_err: got %0b want 1", bus.err); end
        n_checks++; if (bus.m_axi_awvalid !== 1'b1 || bus.m_axi_awlen !== 8'd1) begin n_fail++; $display("FAIL e_4k_fwd: got %0b/%0h want 1/1", bus.m_axi_awvalid, bus.m_axi_awlen); end
        do_reset();
        @(negedge clk); bus.m_axi_arready = 1; bus.rd_req = 1; bus.rd_address = 64'h1008; bus.rd_len = 8'd0;
        @(negedge clk); bus.rd_req = 0; #1;
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL e_misalign_err: got %0b want 1", bus.err); end
        n_checks++; if (bus.m_axi_arvalid !== 1'b1 || bus.m_axi_araddr !== 64'h1008) begin n_fail++; $display("FAIL e_misalign_fwd: got %0b/%0h want 1/1008", bus.m_axi_arvalid, bus.m_axi_araddr); end
        do_reset();
        @(negedge clk); bus.m_axi_awready = 1; bus.wr_req = 1; bus.wr_address = 64'h0; bus.wr_len = 8'd0;
        @(negedge clk); bus.wr_req = 0;
        @(negedge clk); bus.bready = 1; bus.m_axi_bvalid = 1; bus.m_axi_bresp = 2'b10; #1;
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL e_slverr_pre: got %0b want 0", bus.err); end
        @(negedge clk); bus.m_axi_bvalid = 0; #1;
        n_checks++; if (bus.bresp !== 1'b1) begin n_fail++; $display("FAIL e_slverr_pulse: got %0b want 1", bus.bresp); end
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL e_slverr_err: got %0b want 1", bus.err); end
        do_reset();
        @(negedge clk); bus.w_beat = 1; #1;
        n_checks++; if (bus.m_axi_wlast !== 1'b0) begin n_fail++; $display("FAIL e_wempty_wlast: got %0b want 0", bus.m_axi_wlast); end
        @(negedge clk); bus.w_beat = 0; #1;
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL e_wempty_err: got %0b want 1", bus.err); end
        do_reset();
    endtask

    task automatic test_reset_midflight();
        @(negedge clk); idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bus.rd_req = 1; bus.rd_len = 8'd0;
            bus.rd_address = (i == 0) ? 64'h5008 : 64'h5000 + 64'(i * 64);
        end
        @(negedge clk); bus.rd_req = 0; bus.wr_req = 1; bus.wr_address = 64'h6000; bus.wr_len = 8'd3;
        @(negedge clk); bus.wr_req = 0; bus.w_beat = 1;
        @(negedge clk); #1;
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL mf_err_pre: got %0b want 1", bus.err); end
        @(negedge clk); bus.w_beat = 0; rst = 1'b1; #1;
        n_checks++; if (bus.m_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL mf_arvalid_rst: got %0b want 0", bus.m_axi_arvalid); end
        @(negedge clk); rst = 1'b0; #1;
        n_checks++; if (bus.m_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL mf_arvalid: got %0b want 0", bus.m_axi_arvalid); end
        n_checks++; if (bus.m_axi_awvalid !== 1'b0) begin n_fail++; $display("FAIL mf_awvalid: got %0b want 0", bus.m_axi_awvalid); end
        n_checks++; if (bus.m_axi_wlast !== 1'b0) begin n_fail++; $display("FAIL mf_wlast: got %0b want 0", bus.m_axi_wlast); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL mf_err: got %0b want 0", bus.err); end
        @(negedge clk); bus.rd_req = 1; bus.rd_address = 64'h8000; bus.rd_len = 8'd2;
        bus.wr_req = 1; bus.wr_address = 64'h7000; bus.wr_len = 8'd1; bus.m_axi_awready = 1; #1;
        n_checks++; if (bus.rd_req_ack !== 1'b1 || bus.wr_req_ack !== 1'b1) begin n_fail++; $display("FAIL mf_acks: got %0b/%0b want 1/1", bus.rd_req_ack, bus.wr_req_ack); end
        @(negedge clk); bus.rd_req = 0; bus.wr_req = 0; bus.w_beat = 1; #1;
        n_checks++; if (bus.m_axi_arvalid !== 1'b1 || bus.m_axi_araddr !== 64'h8000) begin n_fail++; $display("FAIL mf_new_ar: got %0b/%0h want 1/8000", bus.m_axi_arvalid, bus.m_axi_araddr); end
        n_checks++; if (bus.m_axi_wlast !== 1'b0) begin n_fail++; $display("FAIL mf_beat1: got %0b want 0", bus.m_axi_wlast); end
        @(negedge clk); #1;
        n_checks++; if (bus.m_axi_wlast !== 1'b1) begin n_fail++; $display("FAIL mf_beat2: got %0b want 1", bus.m_axi_wlast); end
        @(negedge clk); bus.w_beat = 0; #1;
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL mf_err_post: got %0b want 0", bus.err); end
        do_reset();
    endtask

    task automatic test_random(input int n_cyc);
        cmd_s        rq[$];
        cmd_s        awq[$];
        int          wq[$];
        int          beat = 0;
        int          outst = 0;
        bit          err_m = 0;
        bit          bresp_m = 0;
        bit          rp = 0, wp = 0;
        logic [63:0] ra = '0, wa = '0;
        logic [7:0]  rl = '0, wl = '0;
        bit          arr, awr, wb, bv, br, e_rack, e_wack, e_wlast, aw_hs, b_hs;
        idle_inputs();
        for (int c = 0; c < n_cyc; c++) begin
            @(negedge clk);
            if (!rp && $urandom_range(0, 2) == 0) begin rp = 1; ra = rand_addr(); rl = 8'($urandom_range(0, 15)); end
            if (!wp && $urandom_range(0, 2) == 0) begin wp = 1; wa = rand_addr(); wl = 8'($urandom_range(0, 7)); end
            arr = ($urandom_range(0, 1) == 1);
            awr = ($urandom_range(0, 1) == 1);
            wb  = (wq.size() > 0) && ($urandom_range(0, 1) == 1);
            bv  = (outst > 0) && ($urandom_range(0, 2) == 0);
            br  = ($urandom_range(0, 3) != 0);
            bus.rd_req = rp; bus.rd_address = ra; bus.rd_len = rl;
            bus.wr_req = wp; bus.wr_address = wa; bus.wr_len = wl;
            bus.m_axi_arready = arr; bus.m_axi_awready = awr; bus.w_beat = wb;
            bus.m_axi_bvalid = bv; bus.bready = br; bus.m_axi_bresp = 2'b00;
            #1;
            e_rack  = rp && (rq.size() < DEPTH);
            e_wack  = wp && (awq.size() < DEPTH) && (wq.size() < DEPTH);
            e_wlast = (wq.size() > 0) && (beat == wq[0]);
            n_checks++; if (bus.rd_req_ack !== e_rack) begin n_fail++; $display("FAIL rnd_rd_ack c%0d: got %0b want %0b", c, bus.rd_req_ack, e_rack); end
            n_checks++; if (bus.wr_req_ack !== e_wack) begin n_fail++; $display("FAIL rnd_wr_ack c%0d: got %0b want %0b", c, bus.wr_req_ack, e_wack); end
            n_checks++; if (bus.m_axi_arvalid !== (rq.size() != 0)) begin n_fail++; $display("FAIL rnd_arvalid c%0d: got %0b want %0b", c, bus.m_axi_arvalid, rq.size() != 0); end
            n_checks++; if (bus.m_axi_awvalid !== (awq.size() != 0)) begin n_fail++; $display("FAIL rnd_awvalid c%0d: got %0b want %0b", c, bus.m_axi_awvalid, awq.size() != 0); end
            if (rq.size() != 0) begin
                n_checks++; if (bus.m_axi_araddr !== rq[0].addr || bus.m_axi_arlen !== rq[0].len) begin
                    n_fail++; $display("FAIL rnd_ar c%0d: got %0h/%0h want %0h/%0h", c, bus.m_axi_araddr, bus.m_axi_arlen, rq[0].addr, rq[0].len);
                end
            end
            if (awq.size() != 0) begin
                n_checks++; if (bus.m_axi_awaddr !== awq[0].addr || bus.m_axi_awlen !== awq[0].len) begin
                    n_fail++; $display("FAIL rnd_aw c%0d: got %0h/%0h want %0h/%0h", c, bus.m_axi_awaddr, bus.m_axi_awlen, awq[0].addr, awq[0].len);
                end
            end
            n_checks++; if (bus.m_axi_wlast !== e_wlast) begin n_fail++; $display("FAIL rnd_wlast c%0d: got %0b want %0b", c, bus.m_axi_wlast, e_wlast); end
            n_checks++; if (bus.bresp !== bresp_m) begin n_fail++; $display("FAIL rnd_bresp c%0d: got %0b want %0b", c, bus.bresp, bresp_m); end
            n_checks++; if (bus.err !== err_m) begin n_fail++; $display("FAIL rnd_err c%0d: got %0b want %0b", c, bus.err, err_m); end

            if (rq.size() != 0 && arr) void'(rq.pop_front());
            if (e_rack) begin rq.push_back('{addr: ra, len: rl}); if (req_bad(ra, rl)) err_m = 1; rp = 0; end
            aw_hs = (awq.size() != 0) && awr;
            if (aw_hs) void'(awq.pop_front());
            if (wb) begin
                if (beat == wq[0]) begin void'(wq.pop_front()); beat = 0; end
                else beat++;
            end
            if (e_wack) begin awq.push_back('{addr: wa, len: wl}); wq.push_back(int'(wl)); if (req_bad(wa, wl)) err_m = 1; wp = 0; end
            b_hs = bv && br;
            bresp_m = b_hs;
            outst = outst + (aw_hs ? 1 : 0) - (b_hs ? 1 : 0);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_read_single();
        test_read_backpressure();
        test_write_wlast();
        test_b_pulses();
        test_errors();
        test_reset_midflight();
        test_random(400);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
